// File: rtl/vc_arbiter_ctrl.sv
// Round-robin pop controller: four 6-bit VC FIFOs into one downstream FIFO, plus threshold and error aggregation.
// Latency: pop in cycle t gives push_out/data_out in cycle t+2 (registered); pop itself is combinational.
// Backpressure: pausa_in stalls new pops in the same cycle; up to two in-flight words still push.
//
// Ports:
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   init                holds the block in INIT and loads umbral_*_in every cycle
//   umbral_*_in         thresholds loaded while in INIT; umbral_* drive them to all FIFOs
//   fifo_empty/error    per-VC flags, bit i = VCi
//   fifo_data           per-VC read data, VCi at [DATA_WIDTH*i +: DATA_WIDTH]
//   pausa_in            downstream almost-full
//   pop                 one-hot pop to the VC FIFOs
//   push_out, data_out  registered push to the downstream FIFO
//   state, idle         FSM state (INIT=0, IDLE=1, ACTIVE=2) and IDLE indicator
//   error_out           sticky OR of fifo_error, cleared only by reset
module vc_arbiter_ctrl #(
  parameter int                      DATA_WIDTH      = 6,
  parameter int                      UMBRAL_WIDTH    = 2,
  parameter logic [UMBRAL_WIDTH-1:0] UMBRAL_ALTO_RST = 2,
  parameter logic [UMBRAL_WIDTH-1:0] UMBRAL_BAJO_RST = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRAL_WIDTH-1:0] umbral_alto_in,
  input  logic [UMBRAL_WIDTH-1:0] umbral_bajo_in,
  input  logic [3:0]              fifo_empty,
  input  logic [3:0]              fifo_error,
  input  logic [4*DATA_WIDTH-1:0] fifo_data,
  input  logic                    pausa_in,
  output logic [3:0]              pop,
  output logic                    push_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [UMBRAL_WIDTH-1:0] umbral_alto,
  output logic [UMBRAL_WIDTH-1:0] umbral_bajo,
  output logic [1:0]              state,
  output logic                    idle,
  output logic                    error_out
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;        // VC granted most recently
  logic [3:0]              last_q, last_d;      // one-hot grant of the previous cycle
  logic                    s1_vld_q, s1_vld_d;  // FIFO read data valid this cycle
  logic [1:0]              s1_sel_q, s1_sel_d;
  logic                    push_q, push_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [UMBRAL_WIDTH-1:0] alto_q, alto_d;
  logic [UMBRAL_WIDTH-1:0] bajo_q, bajo_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   vc_word [4];
  logic [3:0]              eligible;
  logic                    grant_vld;
  logic [1:0]              grant_idx;
  logic [1:0]              cand;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      vc_word[i] = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Circular search starting just after the last grant; the previous
  // cycle's VC is masked so its registered empty flag has time to update.
  always_comb begin
    eligible  = ~fifo_empty & ~last_q;
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    // A pop during reset would consume a word the pipeline is about to drop.
    if (reset || pausa_in || (state_q != ST_ACTIVE)) begin
      grant_vld = 1'b0;
    end
  end

  assign pop = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE:   if (fifo_empty != 4'hF) state_d = ST_ACTIVE;
      // Stay active until both pipeline stages have drained.
      ST_ACTIVE: if ((fifo_empty == 4'hF) && !s1_vld_q && !push_q) state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
    if (init) state_d = ST_INIT;

    ptr_d    = grant_vld ? grant_idx : ptr_q;
    last_d   = pop;
    s1_vld_d = grant_vld;
    s1_sel_d = grant_vld ? grant_idx : s1_sel_q;
    push_d   = s1_vld_q;
    data_d   = s1_vld_q ? vc_word[s1_sel_q] : data_q;
    alto_d   = (state_q == ST_INIT) ? umbral_alto_in : alto_q;
    bajo_d   = (state_q == ST_INIT) ? umbral_bajo_in : bajo_q;
    err_d    = err_q | (|fifo_error);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      ptr_q    <= 2'd3;
      last_q   <= 4'b0000;
      s1_vld_q <= 1'b0;
      s1_sel_q <= 2'd0;
      push_q   <= 1'b0;
      data_q   <= '0;
      alto_q   <= UMBRAL_ALTO_RST;
      bajo_q   <= UMBRAL_BAJO_RST;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      s1_vld_q <= s1_vld_d;
      s1_sel_q <= s1_sel_d;
      push_q   <= push_d;
      data_q   <= data_d;
      alto_q   <= alto_d;
      bajo_q   <= bajo_d;
      err_q    <= err_d;
    end
  end

  assign push_out    = push_q;
  assign data_out    = data_q;
  assign umbral_alto = alto_q;
  assign umbral_bajo = bajo_q;
  assign state       = state_q;
  assign idle        = (state_q == ST_IDLE);
  assign error_out   = err_q;

endmodule

// File: doc/vc_arbiter_ctrl.md
Name: vc_arbiter_ctrl

Overview:
- Round-robin controller sitting between four 6-bit input FIFOs (VC0..VC3) and one downstream 6-bit FIFO.
- Pops at most one input FIFO per cycle and forwards the word to the downstream FIFO's push port.
- Honours downstream Pausa back-pressure and never pops an empty FIFO.
- Also owns the FIFO threshold configuration (umbral registers) and aggregates FIFO error flags.

Parameters:
DATA_WIDTH, 6, word width of every FIFO
UMBRAL_WIDTH, 2, width of almost-full/almost-empty threshold fields
UMBRAL_ALTO_RST, 2, reset value of the almost-full threshold
UMBRAL_BAJO_RST, 1, reset value of the almost-empty threshold

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous reset, active-high
init  input  1  1 = hold in INIT state and load thresholds
umbral_alto_in  input  UMBRAL_WIDTH  almost-full threshold to load during INIT
umbral_bajo_in  input  UMBRAL_WIDTH  almost-empty threshold to load during INIT
fifo_empty  input  4  per-FIFO Fifo_Empty flags, bit i = VCi
fifo_error  input  4  per-FIFO Error_Fifo flags
fifo_data  input  4*DATA_WIDTH  per-FIFO Fifo_Data_out; VCi occupies bits [6i+5:6i]
pausa_in  input  1  downstream FIFO Pausa (almost full)
pop  output  4  one-hot (or zero) pop to input FIFOs; combinational
push_out  output  1  push to downstream FIFO; registered
data_out  output  DATA_WIDTH  word to downstream FIFO; registered
umbral_alto  output  UMBRAL_WIDTH  threshold currently driven to all FIFOs
umbral_bajo  output  UMBRAL_WIDTH  threshold currently driven to all FIFOs
state  output  2  encoding: INIT=0, IDLE=1, ACTIVE=2
idle  output  1  1 while in IDLE
error_out  output  1  sticky OR of fifo_error

Behaviour:
Reset (reset=1 at a clk edge):
- state=INIT; pop=0; push_out=0; data_out=0.
- umbral_alto=UMBRAL_ALTO_RST; umbral_bajo=UMBRAL_BAJO_RST.
- idle=0; error_out=0.
- Round-robin pointer=3, so the first grant goes to VC0.
- Pipeline valid bits are cleared, so in-flight words are dropped.
- Reset mid-operation: push_out=0 from the next cycle.

FSM:
- INIT: umbral_alto/bajo are loaded from the *_in ports on every cycle. INIT->IDLE when init=0.
- IDLE: idle=1. IDLE->ACTIVE when any fifo_empty bit is 0.
- ACTIVE: arbitration is enabled. ACTIVE->IDLE when fifo_empty=4'hF and both pipeline stages are empty.
- From any state, init=1 forces INIT on the next edge; in-flight words still complete.

Grant (combinational, ACTIVE only):
- Eligible set: VCi with fifo_empty[i]=0 and i != the VC granted in the previous cycle.
- The same VC is never popped in back-to-back cycles, which lets its registered empty flag settle.
- pop[i]=1 for the first eligible VC after the pointer, searching circularly 0..3.
- No pop at all when pausa_in=1 or state!=ACTIVE.
- The pointer updates to i on every grant.

Datapath:
- pop[i] asserted in cycle t -> FIFO data valid in cycle t+1.
- The block captures fifo_data[i] at the end of t+1, giving push_out=1 and data_out=word in cycle t+2. Fixed latency 2.
- Throughput: 1 word/cycle with 2+ non-empty VCs; 1 word per 2 cycles with a single non-empty VC.

Back-pressure:
- pausa_in=1 blocks new pops in the same cycle.
- Up to 2 in-flight words still push. The downstream Pausa threshold must therefore leave at least 2 free entries.

Errors:
- error_out is set on any cycle with fifo_error!=0.
- It is cleared only by reset, not by init.

Width rules:
- Threshold values pass through unchanged.
- No arithmetic on data; the pointer wraps 3->0.

Test Plan:
1. Reset, init=1 with umbral_alto_in=3, umbral_bajo_in=0, then init=0 -> umbral_alto=3, umbral_bajo=0, state goes INIT->IDLE, idle=1, pop=0.
2. VC0..VC3 each holding one word (0x01, 0x12, 0x23, 0x34), pausa_in=0 -> pop order 1,2,4,8 on consecutive cycles; push_out=1 in cycles t+2..t+5 with data_out 0x01, 0x12, 0x23, 0x34; then state returns to IDLE.
3. Only VC2 non-empty with 3 words -> pop=4'b0100 on alternate cycles only; three pushes, spaced 2 cycles apart.
4. Streaming from VC0 and VC1 with pausa_in raised at cycle t -> pop=0 from cycle t; exactly the words popped at t-1 and t-2 are pushed, then push_out=0 until pausa_in=0.
5. fifo_error=4'b0010 for one cycle -> error_out=1 and stays 1 through an init pulse; cleared only by reset.
6. reset=1 one cycle after a pop -> no push_out on the following cycles; state=INIT and the pointer restarts at VC0.
